// File: rtl/intr_controller_if.sv
// Request/acknowledge and address-side signals between the CPU, the peripheral
// interrupt lines and the interrupt controller.
interface intr_controller_if #(
    parameter int BITS     = 32,
    parameter int NSRC     = 4,
    parameter int VEC_BITS = 2
);
    logic [BITS-1:0]     ABUS;
    logic                WE;
    logic [NSRC-1:0]     SRC;
    logic                IACK;
    logic                IRQ;
    logic [VEC_BITS-1:0] IVEC;

    modport master (output ABUS, output WE, output SRC, output IACK, input IRQ, input IVEC);
    modport slave  (input ABUS, input WE, input SRC, input IACK, output IRQ, output IVEC);
endinterface

// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: edge-captured pending bits, mask, global
// enable, fixed lowest-index priority and a single-outstanding REQ/IACK/EOI handshake.
module intr_controller #(
    parameter int              BITS     = 32,
    parameter int              NSRC     = 4,
    parameter int              VEC_BITS = 2,
    parameter logic [BITS-1:0] BASE     = 32'hFFFFF100
) (
    input  logic            CLK,
    input  logic            RST_N,
    inout  wire  [BITS-1:0] DBUS,
    intr_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

    localparam logic [BITS-1:0] A_IPEND  = BASE;
    localparam logic [BITS-1:0] A_IMASK  = BASE + 4;
    localparam logic [BITS-1:0] A_ICAUSE = BASE + 8;
    localparam logic [BITS-1:0] A_ICTRL  = BASE + 12;

    logic [NSRC-1:0]     ipend_q, ipend_d, imask_q, imask_d, src_prev_q;
    logic                gie_q, gie_d, armed_q, irq_q, irq_d;
    state_t              state_q, state_d;
    logic [VEC_BITS-1:0] cur_q, cur_d, win_idx;
    logic [NSRC-1:0]     rise, clr, elig;
    logic [BITS-1:0]     rdata;
    logic                sel_pend, sel_mask, sel_cause, sel_ctrl, any_sel;
    logic                wr_pend, wr_mask, wr_ctrl, eoi;

    assign sel_pend  = (bus.ABUS == A_IPEND);
    assign sel_mask  = (bus.ABUS == A_IMASK);
    assign sel_cause = (bus.ABUS == A_ICAUSE);
    assign sel_ctrl  = (bus.ABUS == A_ICTRL);
    assign any_sel   = sel_pend | sel_mask | sel_cause | sel_ctrl;
    assign wr_pend   = bus.WE & sel_pend;
    assign wr_mask   = bus.WE & sel_mask;
    assign wr_ctrl   = bus.WE & sel_ctrl;
    assign eoi       = wr_ctrl & DBUS[1];
    assign elig      = ipend_q & imask_q;

    // Edge detection is held off for the first cycle after reset so lines that
    // were already high during reset are not mistaken for fresh requests.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_edge
        assign rise[gi] = armed_q & bus.SRC[gi] & ~src_prev_q[gi];
    end

    always_comb begin
        win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) win_idx = VEC_BITS'(i);
        end
    end

    always_comb begin
        clr = wr_pend ? DBUS[NSRC-1:0] : '0;
        if (state_q == REQ && bus.IACK) clr[cur_q] = 1'b1;
        ipend_d = (ipend_q & ~clr) | rise;
        imask_d = wr_mask ? DBUS[NSRC-1:0] : imask_q;
        gie_d   = wr_ctrl ? DBUS[0] : gie_q;
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE: begin
                if (gie_q && (|elig)) begin
                    state_d = REQ;
                    cur_d   = win_idx;
                end
            end
            REQ: begin
                if (bus.IACK)
                    state_d = SERVICE;
                else if (!ipend_q[cur_q] || !imask_q[cur_q] || !gie_q)
                    state_d = IDLE;
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == REQ);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ipend_q    <= '0;
            imask_q    <= '0;
            gie_q      <= 1'b0;
            src_prev_q <= '0;
            armed_q    <= 1'b0;
            state_q    <= IDLE;
            cur_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            ipend_q    <= ipend_d;
            imask_q    <= imask_d;
            gie_q      <= gie_d;
            src_prev_q <= bus.SRC;
            armed_q    <= 1'b1;
            state_q    <= state_d;
            cur_q      <= cur_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_pend) rdata[NSRC-1:0] = ipend_q;
        if (sel_mask) rdata[NSRC-1:0] = imask_q;
        if (sel_cause) begin
            rdata[VEC_BITS-1:0] = cur_q;
            rdata[BITS-1]       = (state_q != IDLE);
        end
        if (sel_ctrl) begin
            rdata[0]   = gie_q;
            rdata[3:2] = state_q;
        end
    end

    assign DBUS     = (!bus.WE && any_sel) ? rdata : {BITS{1'bz}};
    assign bus.IRQ  = irq_q;
    assign bus.IVEC = cur_q;
endmodule

// File: tb/tb_intr_controller.sv
// Directed handshake scenarios plus randomized traffic, checked every cycle
// against a behavioural model of the interrupt controller.
module tb_intr_controller;
    localparam logic [31:0] A_PEND  = 32'hFFFFF100;
    localparam logic [31:0] A_MASK  = 32'hFFFFF104;
    localparam logic [31:0] A_CAUSE = 32'hFFFFF108;
    localparam logic [31:0] A_CTRL  = 32'hFFFFF10C;
    localparam logic [31:0] A_NONE  = 32'hFFFFF110;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] tb_d;
    logic        tb_oe;
    wire  [31:0] dbus;
    int          n_chk = 0;
    int          n_fail = 0;

    intr_controller_if #(.BITS(32), .NSRC(4), .VEC_BITS(2)) bus ();

    intr_controller #(.BITS(32), .NSRC(4), .VEC_BITS(2), .BASE(32'hFFFFF100)) dut (
        .CLK(CLK), .RST_N(RST_N), .DBUS(dbus), .bus(bus.slave)
    );

    assign dbus = tb_oe ? tb_d : 32'bz;
    always #5 CLK = ~CLK;

    // Behavioural model: st 0=idle, 1=requesting, 2=in service
    bit [3:0] m_pend = 0, m_mask = 0, m_prev = 0, m_new;
    bit       m_gie = 0, m_armed = 0;
    int       m_st = 0, m_cur = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_pend = 0; m_mask = 0; m_prev = 0; m_gie = 0;
            m_armed = 0; m_st = 0; m_cur = 0;
        end else begin
            m_new = m_pend;
            if (bus.WE && bus.ABUS == A_PEND) m_new = m_new & ~tb_d[3:0];
            if (m_st == 1 && bus.IACK) m_new[m_cur] = 0;
            for (int i = 0; i < 4; i++)
                if (m_armed && bus.SRC[i] && !m_prev[i]) m_new[i] = 1;
            if (m_st == 0) begin
                if (m_gie && (m_pend & m_mask) != 0) begin
                    m_cur = 0;
                    while (!(m_pend[m_cur] && m_mask[m_cur])) m_cur++;
                    m_st = 1;
                end
            end else if (m_st == 1) begin
                if (bus.IACK) m_st = 2;
                else if (!m_pend[m_cur] || !m_mask[m_cur] || !m_gie) m_st = 0;
            end else if (bus.WE && bus.ABUS == A_CTRL && tb_d[1]) begin
                m_st = 0;
            end
            if (bus.WE && bus.ABUS == A_MASK) m_mask = tb_d[3:0];
            if (bus.WE && bus.ABUS == A_CTRL) m_gie = tb_d[0];
            m_pend  = m_new;
            m_prev  = bus.SRC;
            m_armed = 1;
        end
    end

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            A_PEND:  return {28'd0, m_pend};
            A_MASK:  return {28'd0, m_mask};
            A_CAUSE: return {(m_st != 0), 29'd0, 2'(m_cur)};
            A_CTRL:  return {28'd0, 2'(m_st), 1'b0, m_gie};
            default: return 32'bz;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("irq_model", 32'(bus.IRQ), 32'(m_st == 1));
        chk("ivec_model", 32'(bus.IVEC), 32'(m_cur));
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.ABUS = a; bus.WE = 1'b1; tb_d = d; tb_oe = 1'b1;
        tick();
        bus.WE = 1'b0; tb_oe = 1'b0;
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.ABUS = a; bus.WE = 1'b0;
        #1;
        chk(name, dbus, exp);
        $display("read  addr=%h data=%h", a, dbus);
    endtask

    task automatic iack();
        bus.IACK = 1'b1;
        tick();
        bus.IACK = 1'b0;
        $display("iack  irq=%0b ivec=%0d", bus.IRQ, bus.IVEC);
    endtask

    initial begin
        logic [31:0] a;
        RST_N = 1'b0; tb_oe = 1'b0; tb_d = 0;
        bus.ABUS = 0; bus.WE = 0; bus.IACK = 0; bus.SRC = 4'b0101;
        tick(); tick();
        RST_N = 1'b1;
        // Lines already high across reset must not raise pending
        wr(A_MASK, 32'hF); wr(A_CTRL, 32'h1); tick(); tick();
        rd_chk("held_lines_pend", A_PEND, 32'h0);
        chk("held_lines_irq", 32'(bus.IRQ), 32'h0);
        bus.SRC = 4'b0000; wr(A_MASK, 32'h4); tick();

        // Single source, full handshake
        bus.SRC = 4'b0100; tick();
        chk("src2_irq_early", 32'(bus.IRQ), 32'h0);
        rd_chk("src2_pend", A_PEND, 32'h4);
        tick();
        chk("src2_irq", 32'(bus.IRQ), 32'h1);
        chk("src2_ivec", 32'(bus.IVEC), 32'h2);
        iack();
        chk("src2_irq_svc", 32'(bus.IRQ), 32'h0);
        rd_chk("src2_pend_clr", A_PEND, 32'h0);
        rd_chk("src2_cause", A_CAUSE, 32'h80000002);
        wr(A_CTRL, 32'h3);
        rd_chk("src2_cause_eoi", A_CAUSE, 32'h00000002);
        rd_chk("ctrl_idle", A_CTRL, 32'h1);

        // Simultaneous sources: lowest index first, then the next one
        wr(A_MASK, 32'hF);
        bus.SRC = 4'b1110; tick(); tick();
        chk("pri_ivec1", 32'(bus.IVEC), 32'h1);
        chk("pri_irq1", 32'(bus.IRQ), 32'h1);
        iack();
        wr(A_CTRL, 32'h3);
        chk("pri_gap", 32'(bus.IRQ), 32'h0);
        tick();
        chk("pri_irq3", 32'(bus.IRQ), 32'h1);
        chk("pri_ivec3", 32'(bus.IVEC), 32'h3);
        iack(); wr(A_CTRL, 32'h3);
        bus.SRC = 4'b0000; tick();

        // Withdraw by masking, then re-request
        bus.SRC = 4'b0001; tick(); tick();
        chk("wd_irq", 32'(bus.IRQ), 32'h1);
        wr(A_MASK, 32'h0); tick();
        chk("wd_irq_drop", 32'(bus.IRQ), 32'h0);
        rd_chk("wd_ctrl_idle", A_CTRL, 32'h1);
        rd_chk("wd_pend_kept", A_PEND, 32'h1);
        wr(A_MASK, 32'hF); tick();
        chk("wd_rereq", 32'(bus.IRQ), 32'h1);
        chk("wd_ivec0", 32'(bus.IVEC), 32'h0);
        iack(); wr(A_CTRL, 32'h3);
        bus.SRC = 4'b0000; tick();

        // Set beats clear: W1C collision, then IACK collision
        bus.SRC = 4'b0010; wr(A_PEND, 32'h2);
        rd_chk("w1c_collide", A_PEND, 32'h2);
        bus.SRC = 4'b0000; tick();
        chk("col_req_ivec", 32'(bus.IVEC), 32'h1);
        bus.SRC = 4'b0010; iack();
        rd_chk("iack_collide", A_PEND, 32'h2);
        rd_chk("iack_cause", A_CAUSE, 32'h80000001);

        // Asynchronous reset while in service
        #2 RST_N = 1'b0;
        #1 chk("arst_irq", 32'(bus.IRQ), 32'h0);
        rd_chk("arst_cause", A_CAUSE, 32'h0);
        rd_chk("arst_mask", A_MASK, 32'h0);
        bus.SRC = 4'b0000; tick(); tick();
        RST_N = 1'b1;
        wr(A_MASK, 32'hF); wr(A_CTRL, 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom % 3 == 0) bus.SRC = bus.SRC ^ 4'($urandom_range(0, 15));
            case ($urandom % 12)
                0:       wr(A_MASK, $urandom);
                1:       wr(A_CTRL, {30'd0, 1'($urandom), 1'($urandom % 8 != 0)});
                2:       wr(A_PEND, $urandom);
                3, 4, 5: iack();
                default: begin
                    case ($urandom % 5)
                        0: a = A_PEND;
                        1: a = A_MASK;
                        2: a = A_CAUSE;
                        3: a = A_CTRL;
                        default: a = A_NONE;
                    endcase
                    rd_chk("rand_read", a, m_read(a));
                    tick();
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
- Memory-mapped interrupt controller on the shared ABUS/DBUS I/O bus.
- Collects INTR lines from peripheral devices (switch, key, timer, ...) into per-source pending bits, applies a mask and a global enable, and arbitrates them by fixed priority.
- Sequences a single-outstanding request/acknowledge/end-of-interrupt handshake with the CPU.

Parameters:
BITS, 32, bus address/data width
NSRC, 4, number of interrupt sources (max 16)
VEC_BITS, 2, width of vector index (ceil log2 NSRC, min 1)
BASE, 32'hFFFFF100, base address; IPEND=BASE, IMASK=BASE+4, ICAUSE=BASE+8, ICTRL=BASE+12

Ports:
CLK  in  1  system clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
ABUS  in  BITS  address bus
DBUS  inout  BITS  data bus; driven only on reads of own registers, else high-Z
WE  in  1  write enable; registered write on CLK edge when address matches
SRC  in  NSRC  device interrupt lines, synchronous to CLK, active high
IACK  in  1  CPU acknowledge, one-cycle pulse
IRQ  out  1  interrupt request to CPU
IVEC  out  VEC_BITS  index of the source being requested/serviced

Behaviour:
- Reset (RST_N=0, immediate): IPEND=0, IMASK=0, GIE=0, CUR=0, SRC_prev=0, state=IDLE, IRQ=0, IVEC=0. Reset mid-handshake abandons it; no EOI needed afterwards.
- Edge capture: SRC_prev registers SRC each cycle. IPEND[i] sets when SRC[i]=1 and SRC_prev[i]=0. A level held high sets pending only once.
- IPEND write: write-1-to-clear; bits written 0 are unchanged.
- IMASK: read/write, NSRC LSBs; upper bits read 0.
- ICTRL:
  - bit0 = GIE, read/write.
  - bit1 = EOI, write-only, self-clearing, reads 0.
  - bits[3:2] read current state encoding.
- ICAUSE (read-only):
  - [VEC_BITS-1:0] = CUR.
  - bit31 = 1 when state is REQ or SERVICE.
- Set/clear collision: if a rising edge and a clear (W1C or IACK) hit the same bit in the same cycle, set wins.
- Priority: lowest index among (IPEND & IMASK) wins; no preemption or nesting.
- State machine:
  - IDLE: IRQ=0. If GIE=1 and (IPEND & IMASK)!=0 at an edge, latch CUR=winner and go to REQ. IRQ rises the cycle after the pending bit is visible (1-cycle latency from the register update).
  - REQ: IRQ=1, IVEC=CUR.
    - If IACK=1: clear IPEND[CUR] and go to SERVICE.
    - Else if IPEND[CUR] was cleared by software, IMASK[CUR]=0, or GIE=0: withdraw and go to IDLE (IRQ drops next cycle).
    - CUR is not re-arbitrated while in REQ, even if a higher-priority source arrives.
  - SERVICE: IRQ=0, IVEC holds CUR; new pending bits accumulate. An EOI write goes to IDLE, and a new REQ can start the following cycle.
  - IACK outside REQ is ignored. EOI outside SERVICE is ignored.
- Reads are combinational:
  - DBUS = selected register when address matches and WE=0.
  - DBUS = {BITS{1'bz}} otherwise.
  - Unused register bits read 0.

Test Plan:
- Reset with SRC=4'b0101 held high, RST_N released, IMASK=4'hF, GIE=1 -> IPEND stays 0, IRQ=0 (no edge seen).
- SRC[2] rises, IMASK=4'b0100, GIE=1 -> IPEND=4'b0100, IRQ=1 two cycles after the edge, IVEC=2. IACK pulse -> IPEND=0, IRQ=0, ICAUSE=32'h80000002. EOI write -> ICAUSE bit31=0.
- SRC[3] and SRC[1] rise in the same cycle, all masked on -> IVEC=1. After IACK+EOI -> second REQ with IVEC=3 the cycle after IDLE.
- In REQ for source 0, write IMASK=0 -> IRQ drops without IACK, state=IDLE, IPEND[0] still 1. Restore IMASK -> REQ again with IVEC=0.
- SRC[1] rising edge in the same cycle as a W1C write 4'b0010 to IPEND -> IPEND[1]=1. Separately, IACK for source 1 coinciding with a new SRC[1] edge -> IPEND[1] remains 1 after entering SERVICE.
- Assert RST_N=0 while in SERVICE -> IRQ=0, ICAUSE=0, IMASK=0 immediately, without waiting for CLK.
